gbc_mbc1_responder: RTL
=======================

# gbc_mbc1_responder

Target-side responder for the Game Boy CPU memory bus: accepts byte read/write requests from the core's memory-bus initiator, decodes the cartridge regions, and implements MBC1 banking registers. ROM and external-RAM accesses become requests on a single byte-wide backing-store port with a valid/ready handshake. It sits in the cartridge controller path between the core's memory bus and the system/expansion RAM that holds the virtual GamePak image.

## Interface
- RomAddressWidth, 21: backing ROM address bits (max 21 = 2 MiB). Translated ROM addresses are masked to this width.
- RamAddressWidth, 15: external RAM address bits (0 = no RAM; max 15 = 32 KiB). Translated RAM addresses are masked to this width.
- Clk  in  1  single clock; reset is synchronous and active-high
- Reset  in  1  synchronous, active-high
- BusAccess  in  1  request strobe; accepted only when BusReady=1
- BusWrite  in  1  1 = write, 0 = read; sampled with BusAccess
- BusAddress  in  16  CPU address
- BusDataIn  in  8  write data
- BusDataOut  out  8  read data; holds its value until the next read completes
- BusReady  out  1  idle, able to accept a request
- BusDataReady  out  1  one-cycle pulse; BusDataOut valid
- MemAccess  out  1  backing-store request; held until MemReady=1
- MemWrite  out  1  1 = write
- MemAddress  out  22  bit 21: 0 = ROM, 1 = RAM; [20:0] byte offset
- MemDataOut  out  8  write data
- MemDataIn  in  8  read data
- MemReady  in  1  backing store accepts the request this cycle
- MemDataReady  in  1  one-cycle pulse; MemDataIn valid

## Operation
- Registers and reset values: RamEn=0, Bank1[4:0]=0, Bank2[1:0]=0, Mode=0.
- Bank1Eff = (Bank1==0) ? 1 : Bank1.
- Register writes complete internally with no MemAccess:
  - 0000-1FFF: RamEn = (data[3:0]==4'hA).
  - 2000-3FFF: Bank1 = data[4:0].
  - 4000-5FFF: Bank2 = data[1:0].
  - 6000-7FFF: Mode = data[0].
- ROM reads:
  - 0000-3FFF: offset = {Mode ? Bank2 : 2'b0, 5'b0, A[13:0]}.
  - 4000-7FFF: offset = {Bank2, Bank1Eff, A[13:0]}.
  - Both are masked to RomAddressWidth. MemAddress[21]=0.
- RAM, A000-BFFF:
  - Requires RamEn=1 and RamAddressWidth>0.
  - offset = {Mode ? Bank2 : 2'b0, A[12:0]}, masked to RamAddressWidth. MemAddress[21]=1.
  - Reads and writes both go to the backing store.
- Internal response, no MemAccess:
  - Applies to RAM accesses while the RAM is disabled, and to any other address (8000-9FFF, C000-FFFF).
  - Reads return 8'hFF. Writes are dropped.
- FSM states:
  - IDLE: BusReady=1. BusAccess=1 latches the request. An internal response goes to RESPOND. A memory request goes to ISSUE.
  - ISSUE: MemAccess=1 with stable MemAddress, MemWrite and MemDataOut. On MemReady=1: a write goes to RESPOND; a read goes to WAIT_DATA.
  - WAIT_DATA: on MemDataReady=1, latch MemDataIn and go to RESPOND.
  - RESPOND: on a read, pulse BusDataReady with BusDataOut driven. Return to IDLE.
- Boundary conditions:
  - BusAccess while BusReady=0 is ignored.
  - MemDataReady outside WAIT_DATA is ignored.
  - MemDataReady in the same cycle as the transfer is not possible; the backing store guarantees at least 1 cycle.
  - Reset in any state returns to IDLE and restores register defaults. Any outstanding memory read is abandoned.

## Timing
- Outputs during Reset and on the first cycle after it:
  - BusReady=0 while Reset=1, and 1 on the first cycle after Reset falls.
  - BusDataReady=0, BusDataOut=8'hFF, MemAccess=0, MemWrite=0, MemAddress=0, MemDataOut=0.
- Let T be the acceptance cycle.
- Internal access: BusDataReady (reads only) at T+1. BusReady=0 at T+1 and 1 at T+2.
- Memory read:
  - MemAccess asserted from T+1 until the transfer cycle X (X=T+1 if MemReady is already high).
  - MemDataReady arrives at X+k, k≥1.
  - BusDataReady pulses at X+k+1. BusReady returns at X+k+2.
- Memory write: transfer at X. BusReady=0 at X+1 (RESPOND) and 1 at X+2.
- Register write: same timing as an internal access.
- All outputs are registered. Nothing on the Bus side depends combinationally on the Mem side.

## Test plan
- Reset, then read 0x0150, with MemReady=1 and memory latency k=2 returning 0x3C:
  - MemAddress=0x000150 and MemAccess high exactly at T+1.
  - BusDataOut=0x3C with BusDataReady at T+4.
- Banking:
  - Write 0x2000←0x00, then read 0x4000 → MemAddress=0x004000.
  - Write 0x2000←0x05 and 0x4000←0x02, then read 0x7FFF → MemAddress=0x117FFF.
- RAM gating:
  - Read 0xA000 with RAM disabled → 0xFF at T+1 and no MemAccess.
  - Write 0x0000←0x0A, then write 0xA123←0x5A → MemAccess with MemWrite=1, MemAddress=0x200123, MemDataOut=0x5A.
- Mode 1:
  - Write 0x6000←0x01 and 0x4000←0x03, then read 0x0000 → MemAddress=0x180000.
  - With RAM enabled, read 0xB000 → MemAddress=0x207000.
- Backpressure: hold MemReady=0 for 3 cycles during a ROM read.
  - MemAccess, MemAddress and MemWrite stay stable.
  - BusAccess pulses during the stall are ignored.
  - Exactly one BusDataReady occurs.
- Reset during WAIT_DATA:
  - MemAccess=0 and BusReady=1 on the cycle after Reset falls.
  - A late MemDataReady produces no BusDataReady.
  - A following read of 0x4000 → MemAddress=0x004000, confirming register defaults.

Source files
------------

// File: rtl/gbc_mbc1_responder.sv
// gbc_mbc1_responder: MBC1 cartridge responder that decodes CPU bus accesses and
// bridges ROM/external-RAM traffic onto a byte-wide valid/ready backing-store port.
module gbc_mbc1_responder #(
    parameter int RomAddressWidth = 21,
    parameter int RamAddressWidth = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        BusAccess,
    input  logic        BusWrite,
    input  logic [15:0] BusAddress,
    input  logic [7:0]  BusDataIn,
    output logic [7:0]  BusDataOut,
    output logic        BusReady,
    output logic        BusDataReady,
    output logic        MemAccess,
    output logic        MemWrite,
    output logic [21:0] MemAddress,
    output logic [7:0]  MemDataOut,
    input  logic [7:0]  MemDataIn,
    input  logic        MemReady,
    input  logic        MemDataReady
);
    localparam logic [21:0] RomMaskFull = (22'd1 << RomAddressWidth) - 22'd1;
    localparam logic [21:0] RamMaskFull = (22'd1 << RamAddressWidth) - 22'd1;
    localparam logic [20:0] RomMask = RomMaskFull[20:0];
    localparam logic [20:0] RamMask = RamMaskFull[20:0];
    typedef enum logic [1:0] {Idle, Issue, WaitData, Respond} state_t;
    state_t state, stateNext;
    logic ramEn, ramEnNext, mode, modeNext;
    logic [4:0] bank1, bank1Next, bank1Eff;
    logic [1:0] bank2, bank2Next, upperBank;
    logic [7:0] busDataOutNext, memDataOutNext;
    logic busDataReadyNext, memAccessNext, memWriteNext;
    logic [21:0] memAddressNext;
    logic [20:0] romOffset, ramOffset;
    logic isRom, ramOk;
    assign isRom = ~BusAddress[15];
    assign ramOk = (BusAddress[15:13] == 3'b101) && ramEn && (RamAddressWidth > 0);
    assign bank1Eff = (bank1 == 5'd0) ? 5'd1 : bank1;
    assign upperBank = mode ? bank2 : 2'b00;
    assign romOffset = (BusAddress[14] ? {bank2, bank1Eff, BusAddress[13:0]}
                                       : {upperBank, 5'b0, BusAddress[13:0]}) & RomMask;
    assign ramOffset = {6'b0, upperBank, BusAddress[12:0]} & RamMask;
    // Reset gates BusReady directly so the bus sees "busy" for the whole reset window.
    assign BusReady = (state == Idle) && !Reset;
    always_comb begin
        stateNext = state;
        ramEnNext = ramEn;
        bank1Next = bank1;
        bank2Next = bank2;
        modeNext = mode;
        busDataOutNext = BusDataOut;
        busDataReadyNext = 1'b0;
        memAccessNext = MemAccess;
        memWriteNext = MemWrite;
        memAddressNext = MemAddress;
        memDataOutNext = MemDataOut;
        case (state)
            Idle: if (BusAccess) begin
                if (isRom && BusWrite) begin
                    ramEnNext = (BusAddress[14:13] == 2'd0) ? (BusDataIn[3:0] == 4'hA) : ramEn;
                    bank1Next = (BusAddress[14:13] == 2'd1) ? BusDataIn[4:0] : bank1;
                    bank2Next = (BusAddress[14:13] == 2'd2) ? BusDataIn[1:0] : bank2;
                    modeNext = (BusAddress[14:13] == 2'd3) ? BusDataIn[0] : mode;
                    stateNext = Respond;
                end else if (isRom || ramOk) begin
                    memAccessNext = 1'b1;
                    memWriteNext = BusWrite;
                    memAddressNext = isRom ? {1'b0, romOffset} : {1'b1, ramOffset};
                    memDataOutNext = BusDataIn;
                    stateNext = Issue;
                end else begin
                    busDataOutNext = BusWrite ? BusDataOut : 8'hFF;
                    busDataReadyNext = !BusWrite;
                    stateNext = Respond;
                end
            end
            Issue: if (MemReady) begin
                memAccessNext = 1'b0;
                stateNext = MemWrite ? Respond : WaitData;
            end
            WaitData: if (MemDataReady) begin
                busDataOutNext = MemDataIn;
                busDataReadyNext = 1'b1;
                stateNext = Respond;
            end
            Respond: stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= Idle;
            ramEn <= 1'b0;
            bank1 <= 5'd0;
            bank2 <= 2'd0;
            mode <= 1'b0;
            BusDataOut <= 8'hFF;
            BusDataReady <= 1'b0;
            MemAccess <= 1'b0;
            MemWrite <= 1'b0;
            MemAddress <= 22'd0;
            MemDataOut <= 8'd0;
        end else begin
            state <= stateNext;
            ramEn <= ramEnNext;
            bank1 <= bank1Next;
            bank2 <= bank2Next;
            mode <= modeNext;
            BusDataOut <= busDataOutNext;
            BusDataReady <= busDataReadyNext;
            MemAccess <= memAccessNext;
            MemWrite <= memWriteNext;
            MemAddress <= memAddressNext;
            MemDataOut <= memDataOutNext;
        end
    end
endmodule
